// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 32x32 register file: clears r1..r(NREG-1) after reset,
// then shares the port between ALU (A) and load (B) writeback with round-robin on conflict.
module regfile_write_arbiter #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_gnt,
    input  logic          b_req,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_gnt,
    output logic          write_enable,
    output logic [AW-1:0] write_addr,
    output logic [DW-1:0] write_data,
    output logic          init_done
);

    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {PRI_A, PRI_B} pri_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    // One extra counter bit so the terminal count NREG is representable.
    localparam logic [AW:0] LAST = (AW+1)'(NREG);

    state_t      state;
    pri_t        rr_ptr;
    logic [AW:0] init_cnt;
    logic        port_open;
    logic        xfer;
    wr_t         sel;

    always_comb begin
        port_open = !reset && (state == RUN);
        a_gnt     = port_open && a_req && (!b_req || rr_ptr == PRI_A);
        b_gnt     = port_open && b_req && (!a_req || rr_ptr == PRI_B);
        xfer      = a_gnt || b_gnt;
        sel       = a_gnt ? {a_addr, a_data} : {b_addr, b_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= INIT;
            init_cnt     <= (AW+1)'(1);
            rr_ptr       <= PRI_A;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            init_done    <= 1'b0;
        end else if (state == INIT) begin
            if (init_cnt != LAST) begin
                write_enable <= 1'b1;
                write_addr   <= init_cnt[AW-1:0];
                write_data   <= '0;
                init_cnt     <= init_cnt + (AW+1)'(1);
            end else begin
                write_enable <= 1'b0;
                init_done    <= 1'b1;
                state        <= RUN;
            end
        end else begin
            if (xfer) begin
                // x0 requests are consumed but never strobed into the file.
                write_enable <= (sel.addr != '0);
                write_addr   <= sel.addr;
                write_data   <= sel.data;
                rr_ptr       <= a_gnt ? PRI_B : PRI_A;
            end else begin
                write_enable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expected strobes flow through a scoreboard queue.
module tb_regfile_write_arbiter;

    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, b_req;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_gnt, b_gnt;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          init_done;

    regfile_write_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } exp_t;

    exp_t          exp_q[$];
    int            total = 0;
    int            bad = 0;
    bit            m_run;
    bit            m_rr;      // 0: A favoured, 1: B favoured
    bit            m_done;
    int            m_k;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Inputs are set just after a falling edge; check grants, predict the next strobe,
    // cross the rising edge, then compare registered outputs.
    task automatic cycle();
        bit   eg_a, eg_b;
        exp_t e;
        #1;
        eg_a = 1'b0;
        eg_b = 1'b0;
        if (reset) begin
            m_run = 0; m_rr = 0; m_k = 1; m_done = 0;
            last_addr = '0; last_data = '0;
            e = '{1'b0, '0, '0, 1'b0};
        end else if (!m_run) begin
            if (m_k < NREG) begin
                last_addr = AW'(m_k);
                last_data = '0;
                m_k++;
                e = '{1'b1, last_addr, last_data, m_done};
            end else begin
                m_done = 1;
                m_run = 1;
                e = '{1'b0, last_addr, last_data, 1'b1};
            end
        end else begin
            eg_a = a_req && (!b_req || !m_rr);
            eg_b = b_req && (!a_req || m_rr);
            if (eg_a) begin
                last_addr = a_addr; last_data = a_data; m_rr = 1;
                e = '{(a_addr != 0), a_addr, a_data, 1'b1};
            end else if (eg_b) begin
                last_addr = b_addr; last_data = b_data; m_rr = 0;
                e = '{(b_addr != 0), b_addr, b_data, 1'b1};
            end else begin
                e = '{1'b0, last_addr, last_data, 1'b1};
            end
        end
        chk("a_gnt", DW'(a_gnt), DW'(eg_a));
        chk("b_gnt", DW'(b_gnt), DW'(eg_b));
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total++; bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            chk("write_enable", DW'(write_enable), DW'(e.we));
            chk("write_addr",   DW'(write_addr),   DW'(e.addr));
            chk("write_data",   write_data,        e.data);
            chk("init_done",    DW'(init_done),    DW'(e.done));
        end
    endtask

    initial begin
        reset = 1; a_req = 0; b_req = 0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        @(negedge clk);

        // Reset with A already pending; A must wait out the whole clear.
        a_req = 1; a_addr = 5'd1; a_data = 32'hAABBCCDD;
        cycle(); cycle();
        reset = 0;
        repeat (NREG) cycle();
        cycle();                      // first RUN cycle: A granted
        a_req = 0;
        cycle();                      // strobe addr 1
        cycle();                      // idle: enable low, addr/data held

        // B to x0: granted, no strobe, rr flips back to A.
        b_req = 1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
        cycle();
        b_req = 0;
        cycle();

        // Both held four cycles: A,B,A,B.
        a_req = 1; a_addr = 5'd2; a_data = 32'h11223344;
        b_req = 1; b_addr = 5'd3; b_data = 32'h55667788;
        repeat (4) cycle();
        a_req = 0; b_req = 0;
        cycle();

        // Lone A write leaves rr favouring B, then both hit addr 5.
        a_req = 1; a_addr = 5'd4; a_data = 32'h00000044;
        cycle();
        a_req = 1; a_addr = 5'd5; a_data = 32'd1;
        b_req = 1; b_addr = 5'd5; b_data = 32'd2;
        cycle();                      // B first
        b_req = 0;
        cycle();                      // then A
        a_req = 0;
        cycle();
        chk("x5_final_addr", DW'(write_addr), 32'd5);
        chk("x5_final_data", write_data, 32'd1);

        // Reset lands on a cycle where A is requesting: no grant, clear restarts.
        a_req = 1; a_addr = 5'd7; a_data = 32'h77777777;
        reset = 1;
        cycle();
        chk("rst_done_drop", DW'(init_done), 32'd0);
        reset = 0;
        cycle();
        chk("restart_addr1", DW'(write_addr), 32'd1);
        repeat (NREG - 1) cycle();
        cycle();                      // A granted in RUN
        a_req = 0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file (write_enable / write_addr / write_data).
- Shares that port between two writeback requesters: A is the ALU writeback and B is the load/memory writeback.
- Uses req/gnt handshakes with round-robin on conflict.
- After reset, a sequencer first clears r1..r31 to zero, then opens the port to requesters. Outputs are registered, so the register file sees a clean one-cycle-delayed write.

Parameters:
- NREG, 32, number of architectural registers (power of 2).
- AW, 5, address width, log2(NREG).
- DW, 32, data width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- a_req  input  1  requester A has a write pending; held until granted.
- a_addr  input  AW  requester A destination register.
- a_data  input  DW  requester A write data.
- a_gnt  output  1  A's request accepted this cycle (combinational).
- b_req  input  1  requester B has a write pending; held until granted.
- b_addr  input  AW  requester B destination register.
- b_data  input  DW  requester B write data.
- b_gnt  output  1  B's request accepted this cycle (combinational).
- write_enable  output  1  register-file write strobe (registered).
- write_addr  output  AW  register-file write address (registered).
- write_data  output  DW  register-file write data (registered).
- init_done  output  1  high once the clear sequence has finished (registered).

Behaviour:
- Reset, sampled at a clk edge with reset=1:
  - State goes to INIT, init counter to 1, rr_ptr to A-priority.
  - write_enable=0, write_addr=0, write_data=0, init_done=0.
  - a_gnt=b_gnt=0 for as long as reset is high or the state is INIT.
- Reset mid-operation:
  - Takes effect at the next edge; any pending handshake that cycle is dropped.
  - The clear sequence restarts from r1.
- INIT state:
  - Edge k after reset release (k=1..NREG-1) drives write_enable=1, write_addr=k, write_data=0.
  - Edge NREG drives write_enable=0 and init_done=1, and moves to RUN.
  - The clear therefore takes NREG-1 write cycles; r0 is never written.
  - Requests seen during INIT are ignored; requesters keep req high.
- RUN state, grant logic (combinational):
  - Only a_req: a_gnt=1.
  - Only b_req: b_gnt=1.
  - Both: the side favoured by rr_ptr is granted.
  - At most one gnt is high per cycle.
- Transfer:
  - A transfer occurs on a cycle where req&&gnt.
  - At the following edge, write_addr and write_data take the granted requester's addr and data.
  - write_enable=1 only if that addr != 0.
  - Latency from handshake cycle to write strobe at the register file is 1 cycle.
- Address 0: the request is granted and consumed, but write_enable stays 0, so the x0 write is silently discarded.
- No transfer: at the edge, write_enable=0 and write_addr/write_data hold their previous values.
- rr_ptr:
  - After any grant, points to the other requester.
  - Unchanged when there is no grant.
  - A lone requester therefore gets back-to-back grants, with one write per cycle.
- Same address from both requesters in the same cycle:
  - The two writes are serialised in grant order; the later one wins in the register file.
  - No merging occurs.
- No internal buffering: throughput is 1 write per cycle and the loser waits.
- init_done stays 1 until the next reset.

Test Plan:
- Reset 2 cycles, then release -> write_enable=1 on 31 consecutive cycles with write_addr 1..31 and write_data=0; init_done=1 on the next cycle; a_gnt=b_gnt=0 throughout; a_req=1 held during INIT is not granted until RUN.
- RUN, a_req=1 alone, a_addr=1, a_data=AABBCCDD for 1 cycle -> a_gnt=1 that cycle; next cycle write_enable=1, write_addr=1, write_data=AABBCCDD; then write_enable=0.
- RUN, both req held 4 cycles with rr_ptr=A: A(addr 2, data 11223344) and B(addr 3, data 55667788) -> grants alternate A,B,A,B; strobes alternate addr 2,3,2,3, each one cycle later.
- RUN, b_req with b_addr=0, b_data=FFFFFFFF -> b_gnt=1, write_enable stays 0; the next A request is then favoured (rr flipped).
- Both requesters target addr 5 (A=1, B=2) with rr_ptr=B -> B's write first, A's next; final strobe writes 1 to addr 5.
- Assert reset during a RUN transfer -> no strobe from that transfer; the INIT sequence restarts at write_addr=1; init_done drops to 0.
